control_sequencer: RTL and testbench

//  Moore control FSM driving the 32-bit DataPath control inputs: fetch (T0-T2), decode IR[31:27], execute (T3-T7).

---
 rtl/cpu_pkg.sv | 95 +++++++++
 rtl/cu_decoder.sv | 33 +++
 rtl/control_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: opcodes, ALU codes, state and class encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a (no flow control; the sequencer free-runs one step per clock).
package cpu_pkg;

    localparam int IR_W = 32;
    localparam int OP_W = 5;

    // Opcode field IR[31:27]
    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01010;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_JAL  = 5'b10100;
    localparam logic [OP_W-1:0] OP_IN   = 5'b10101;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b10110;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

    // ALU operation codes used outside the ALU-op instructions themselves
    localparam logic [OP_W-1:0] ALU_ADD    = 5'b00011;
    localparam logic [OP_W-1:0] ALU_INC_PC = 5'b11111;

    // T7 must stay the last execute step: the sequencer advances T3..T6 by +1.
    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        C_MEM,
        C_ALU_R,
        C_ALU_I,
        C_UNARY,
        C_MULDIV,
        C_BR,
        C_JMP,
        C_IO,
        C_HILO,
        C_NOP,
        C_HALT
    } iclass_t;

    // One full control word for the DataPath
    typedef struct packed {
        logic            run;
        logic [OP_W-1:0] alu_code;
        logic            hi_in;
        logic            lo_in;
        logic            z_in;
        logic            pc_in;
        logic            mdr_in;
        logic            mar_in;
        logic            y_in;
        logic            oport_in;
        logic            ir_in;
        logic            hi_out;
        logic            lo_out;
        logic            zhi_out;
        logic            zlo_out;
        logic            pc_out;
        logic            mdr_out;
        logic            iport_out;
        logic            c_out;
        logic            gra;
        logic            grb;
        logic            grc;
        logic            r_in;
        logic            r_out;
        logic            ba_out;
        logic            con_in;
        logic            mem_read;
        logic            mem_write;
    } ctrl_t;

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode -> instruction class decoder; CTRL_MULDIV_EN enables the mul/div class.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the opcode input directly.
module cu_decoder
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0] i_opcode,
    output iclass_t         o_class
);

    // Map each opcode range onto the class that shares its step sequence
    always_comb begin
        o_class = C_NOP;
        case (i_opcode) inside
            [OP_LD:OP_ST]:    o_class = C_MEM;
            [OP_ADD:OP_ROL]:  o_class = C_ALU_R;
            [OP_ADDI:OP_ORI]: o_class = C_ALU_I;
`ifdef CTRL_MULDIV_EN
            OP_MUL, OP_DIV:   o_class = C_MULDIV;
`else
            OP_MUL, OP_DIV:   o_class = C_NOP;
`endif
            OP_NEG, OP_NOT:   o_class = C_UNARY;
            OP_BR:            o_class = C_BR;
            OP_JR, OP_JAL:    o_class = C_JMP;
            OP_IN, OP_OUT:    o_class = C_IO;
            OP_MFHI, OP_MFLO: o_class = C_HILO;
            OP_HALT:          o_class = C_HALT;
            default:          o_class = C_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control FSM for the 32-bit DataPath: fetch T0-T2, decode IR[31:27], execute T3-T7 (CTRL_MULDIV_EN adds mul/div).
// Latency: one control step per clock; outputs are decoded from registered state and latched opcode.
// Backpressure: none; the sequencer free-runs and only HALT or reset stops it.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic            clock,
    input  logic            clear,
    input  logic [IR_W-1:0] IR,
    input  logic            ConOut,
    output logic            HiIn,
    output logic            LoIn,
    output logic            ZIn,
    output logic            PCIn,
    output logic            MDRIn,
    output logic            MARIn,
    output logic            YIn,
    output logic            OPortIn,
    output logic            IRIn,
    output logic            HiOut,
    output logic            LoOut,
    output logic            ZHiOut,
    output logic            ZLoOut,
    output logic            PCOut,
    output logic            MDROut,
    output logic            IPortOut,
    output logic            COut,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            RIn,
    output logic            ROut,
    output logic            BAOut,
    output logic            Conin,
    output logic            memread,
    output logic            memwrite,
    output logic [OP_W-1:0] ALUCode,
    output logic            run
);

    state_t          r_state;
    state_t          w_next;
    logic [OP_W-1:0] r_opcode;
    logic [OP_W-1:0] w_op_src;
    iclass_t         w_class;
    ctrl_t           w_ctrl;
    logic            w_last;
    logic            w_unused_ir;

    // Only the opcode field matters to sequencing; operand fields go to the DataPath directly
    assign w_unused_ir = ^IR[IR_W-OP_W-1:0];

    // During T2 the branch out of fetch depends on the opcode being loaded now;
    // from T3 on, the latched copy is the stable reference.
    assign w_op_src = (r_state == S_T2) ? IR[IR_W-1 -: OP_W] : r_opcode;

    cu_decoder u_decoder (
        .i_opcode (w_op_src),
        .o_class  (w_class)
    );

    // State register and opcode latch; clear low forces RST from any state
    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state  <= S_RST;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_T2) begin
                r_opcode <= IR[IR_W-1 -: OP_W];
            end
        end
    end

    // Next-state and control-word decode for every step
    always_comb begin
        w_next       = r_state;
        w_last       = 1'b0;
        w_ctrl       = '0;
        w_ctrl.run   = 1'b1;
        case (r_state)
            S_RST: begin
                w_next = S_T0;
            end
            S_T0: begin
                w_ctrl.pc_out   = 1'b1;
                w_ctrl.mar_in   = 1'b1;
                w_ctrl.z_in     = 1'b1;
                w_ctrl.alu_code = ALU_INC_PC;
                w_next          = S_T1;
            end
            S_T1: begin
                w_ctrl.zlo_out  = 1'b1;
                w_ctrl.pc_in    = 1'b1;
                w_ctrl.mem_read = 1'b1;
                w_ctrl.mdr_in   = 1'b1;
                w_next          = S_T2;
            end
            S_T2: begin
                w_ctrl.mdr_out = 1'b1;
                w_ctrl.ir_in   = 1'b1;
                case (w_class)
                    C_NOP:   w_next = S_T0;
                    C_HALT:  w_next = S_HALT;
                    default: w_next = S_T3;
                endcase
            end
            S_HALT: begin
                w_ctrl.run = 1'b0;
                w_next     = S_HALT;
            end
            default: begin
                // Execute steps T3..T7; any class/step pair not listed ends the instruction
                case (w_class)
                    C_MEM: begin
                        case (r_state)
                            S_T3: begin
                                w_ctrl.grb    = 1'b1;
                                w_ctrl.ba_out = 1'b1;
                                w_ctrl.y_in   = 1'b1;
                            end
                            S_T4: begin
                                w_ctrl.c_out    = 1'b1;
                                w_ctrl.alu_code = ALU_ADD;
                                w_ctrl.z_in     = 1'b1;
                            end
                            S_T5: begin
                                w_ctrl.zlo_out = 1'b1;
                                if (r_opcode == OP_LDI) begin
                                    w_ctrl.gra  = 1'b1;
                                    w_ctrl.r_in = 1'b1;
                                    w_last      = 1'b1;
                                end else begin
                                    w_ctrl.mar_in = 1'b1;
                                end
                            end
                            S_T6: begin
                                w_ctrl.mdr_in = 1'b1;
                                if (r_opcode == OP_ST) begin
                                    w_ctrl.gra   = 1'b1;
                                    w_ctrl.r_out = 1'b1;
                                end else begin
                                    w_ctrl.mem_read = 1'b1;
                                end
                            end
                            S_T7: begin
                                if (r_opcode == OP_ST) begin
                                    w_ctrl.mem_write = 1'b1;
                                end else begin
                                    w_ctrl.mdr_out = 1'b1;
                                    w_ctrl.gra     = 1'b1;
                                    w_ctrl.r_in    = 1'b1;
                                end
                                w_last = 1'b1;
                            end
                            default: w_last = 1'b1;
                        endcase
                    end
                    C_ALU_R, C_ALU_I: begin
                        case (r_state)
                            S_T3: begin
                                w_ctrl.grb   = 1'b1;
                                w_ctrl.r_out = 1'b1;
                                w_ctrl.y_in  = 1'b1;
                            end
                            S_T4: begin
                                if (w_class == C_ALU_I) begin
                                    w_ctrl.c_out = 1'b1;
                                end else begin
                                    w_ctrl.grc   = 1'b1;
                                    w_ctrl.r_out = 1'b1;
                                end
                                w_ctrl.alu_code = r_opcode;
                                w_ctrl.z_in     = 1'b1;
                            end
                            S_T5: begin
                                w_ctrl.zlo_out = 1'b1;
                                w_ctrl.gra     = 1'b1;
                                w_ctrl.r_in    = 1'b1;
                                w_last         = 1'b1;
                            end
                            default: w_last = 1'b1;
                        endcase
                    end
                    C_UNARY: begin
                        case (r_state)
                            S_T3: begin
                                w_ctrl.grb      = 1'b1;
                                w_ctrl.r_out    = 1'b1;
                                w_ctrl.alu_code = r_opcode;
                                w_ctrl.z_in     = 1'b1;
                            end
                            S_T4: begin
                                w_ctrl.zlo_out = 1'b1;
                                w_ctrl.gra     = 1'b1;
                                w_ctrl.r_in    = 1'b1;
                                w_last         = 1'b1;
                            end
                            default: w_last = 1'b1;
                        endcase
                    end
                    C_MULDIV: begin
                        case (r_state)
                            S_T3: begin
                                w_ctrl.gra   = 1'b1;
                                w_ctrl.r_out = 1'b1;
                                w_ctrl.y_in  = 1'b1;
                            end
                            S_T4: begin
                                w_ctrl.grb      = 1'b1;
                                w_ctrl.r_out    = 1'b1;
                                w_ctrl.alu_code = r_opcode;
                                w_ctrl.z_in     = 1'b1;
                            end
                            S_T5: begin
                                w_ctrl.zlo_out = 1'b1;
                                w_ctrl.lo_in   = 1'b1;
                            end
                            S_T6: begin
                                w_ctrl.zhi_out = 1'b1;
                                w_ctrl.hi_in   = 1'b1;
                                w_last         = 1'b1;
                            end
                            default: w_last = 1'b1;
                        endcase
                    end
                    C_BR: begin
                        case (r_state)
                            S_T3: begin
                                w_ctrl.gra    = 1'b1;
                                w_ctrl.r_out  = 1'b1;
                                w_ctrl.con_in = 1'b1;
                            end
                            S_T4: begin
                                w_ctrl.pc_out = 1'b1;
                                w_ctrl.y_in   = 1'b1;
                            end
                            S_T5: begin
                                w_ctrl.c_out    = 1'b1;
                                w_ctrl.alu_code = ALU_ADD;
                                w_ctrl.z_in     = 1'b1;
                            end
                            S_T6: begin
                                w_ctrl.zlo_out = 1'b1;
                                w_ctrl.pc_in   = ConOut;
                                w_last         = 1'b1;
                            end
                            default: w_last = 1'b1;
                        endcase
                    end
                    C_JMP: begin
                        case (r_state)
                            S_T3: begin
                                if (r_opcode == OP_JR) begin
                                    w_ctrl.gra   = 1'b1;
                                    w_ctrl.r_out = 1'b1;
                                    w_ctrl.pc_in = 1'b1;
                                    w_last       = 1'b1;
                                end else begin
                                    w_ctrl.pc_out = 1'b1;
                                    w_ctrl.grb    = 1'b1;
                                    w_ctrl.r_in   = 1'b1;
                                end
                            end
                            S_T4: begin
                                w_ctrl.gra   = 1'b1;
                                w_ctrl.r_out = 1'b1;
                                w_ctrl.pc_in = 1'b1;
                                w_last       = 1'b1;
                            end
                            default: w_last = 1'b1;
                        endcase
                    end
                    C_IO: begin
                        w_ctrl.gra = 1'b1;
                        if (r_opcode == OP_IN) begin
                            w_ctrl.iport_out = 1'b1;
                            w_ctrl.r_in      = 1'b1;
                        end else begin
                            w_ctrl.r_out    = 1'b1;
                            w_ctrl.oport_in = 1'b1;
                        end
                        w_last = 1'b1;
                    end
                    C_HILO: begin
                        w_ctrl.gra  = 1'b1;
                        w_ctrl.r_in = 1'b1;
                        if (r_opcode == OP_MFHI) begin
                            w_ctrl.hi_out = 1'b1;
                        end else begin
                            w_ctrl.lo_out = 1'b1;
                        end
                        w_last = 1'b1;
                    end
                    default: w_last = 1'b1;
                endcase
                // T7 always sets w_last, so the +1 never walks past the execute steps
                w_next = w_last ? S_T0 : state_t'(r_state + 4'd1);
            end
        endcase
    end

    assign HiIn     = w_ctrl.hi_in;
    assign LoIn     = w_ctrl.lo_in;
    assign ZIn      = w_ctrl.z_in;
    assign PCIn     = w_ctrl.pc_in;
    assign MDRIn    = w_ctrl.mdr_in;
    assign MARIn    = w_ctrl.mar_in;
    assign YIn      = w_ctrl.y_in;
    assign OPortIn  = w_ctrl.oport_in;
    assign IRIn     = w_ctrl.ir_in;
    assign HiOut    = w_ctrl.hi_out;
    assign LoOut    = w_ctrl.lo_out;
    assign ZHiOut   = w_ctrl.zhi_out;
    assign ZLoOut   = w_ctrl.zlo_out;
    assign PCOut    = w_ctrl.pc_out;
    assign MDROut   = w_ctrl.mdr_out;
    assign IPortOut = w_ctrl.iport_out;
    assign COut     = w_ctrl.c_out;
    assign Gra      = w_ctrl.gra;
    assign Grb      = w_ctrl.grb;
    assign Grc      = w_ctrl.grc;
    assign RIn      = w_ctrl.r_in;
    assign ROut     = w_ctrl.r_out;
    assign BAOut    = w_ctrl.ba_out;
    assign Conin    = w_ctrl.con_in;
    assign memread  = w_ctrl.mem_read;
    assign memwrite = w_ctrl.mem_write;
    assign ALUCode  = w_ctrl.alu_code;
    assign run      = w_ctrl.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected control words queued per step, checked each falling edge.
// Latency: one expected word per clock step, compared half a cycle after the step begins.
// Backpressure: none; the monitor drains the queue at one entry per cycle.
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic [31:0] IR;
    logic        ConOut;
    logic        HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
    logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
    logic        Gra, Grb, Grc, RIn, ROut, BAOut, Conin;
    logic        memread, memwrite;
    logic [4:0]  ALUCode;
    logic        run;

    control_sequencer dut (
        .clock(clock), .clear(clear), .IR(IR), .ConOut(ConOut),
        .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn),
        .MARIn(MARIn), .YIn(YIn), .OPortIn(OPortIn), .IRIn(IRIn),
        .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut),
        .PCOut(PCOut), .MDROut(MDROut), .IPortOut(IPortOut), .COut(COut),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .ROut(ROut),
        .BAOut(BAOut), .Conin(Conin), .memread(memread), .memwrite(memwrite),
        .ALUCode(ALUCode), .run(run)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bench-side packing of the control word: run, ALUCode, then the 26 strobes
    localparam logic [31:0] K_MEMWR  = 32'd1 << 0;
    localparam logic [31:0] K_MEMRD  = 32'd1 << 1;
    localparam logic [31:0] K_CONIN  = 32'd1 << 2;
    localparam logic [31:0] K_BAOUT  = 32'd1 << 3;
    localparam logic [31:0] K_ROUT   = 32'd1 << 4;
    localparam logic [31:0] K_RIN    = 32'd1 << 5;
    localparam logic [31:0] K_GRC    = 32'd1 << 6;
    localparam logic [31:0] K_GRB    = 32'd1 << 7;
    localparam logic [31:0] K_GRA    = 32'd1 << 8;
    localparam logic [31:0] K_COUT   = 32'd1 << 9;
    localparam logic [31:0] K_IPOUT  = 32'd1 << 10;
    localparam logic [31:0] K_MDROUT = 32'd1 << 11;
    localparam logic [31:0] K_PCOUT  = 32'd1 << 12;
    localparam logic [31:0] K_ZLOOUT = 32'd1 << 13;
    localparam logic [31:0] K_ZHIOUT = 32'd1 << 14;
    localparam logic [31:0] K_LOOUT  = 32'd1 << 15;
    localparam logic [31:0] K_HIOUT  = 32'd1 << 16;
    localparam logic [31:0] K_IRIN   = 32'd1 << 17;
    localparam logic [31:0] K_OPIN   = 32'd1 << 18;
    localparam logic [31:0] K_YIN    = 32'd1 << 19;
    localparam logic [31:0] K_MARIN  = 32'd1 << 20;
    localparam logic [31:0] K_MDRIN  = 32'd1 << 21;
    localparam logic [31:0] K_PCIN   = 32'd1 << 22;
    localparam logic [31:0] K_ZIN    = 32'd1 << 23;
    localparam logic [31:0] K_LOIN   = 32'd1 << 24;
    localparam logic [31:0] K_HIIN   = 32'd1 << 25;
    localparam logic [31:0] K_RUN    = 32'h8000_0000;

    function automatic logic [31:0] alu(input logic [4:0] c);
        return {1'b0, c, 26'd0};
    endfunction

    localparam logic [31:0] E_T0 = K_RUN | K_PCOUT | K_MARIN | K_ZIN | {1'b0, 5'b11111, 26'd0};
    localparam logic [31:0] E_T1 = K_RUN | K_ZLOOUT | K_PCIN | K_MEMRD | K_MDRIN;
    localparam logic [31:0] E_T2 = K_RUN | K_MDROUT | K_IRIN;

    logic [31:0] dut_word;
    assign dut_word = {run, ALUCode, HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
                       HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
                       Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite};

    typedef struct {
        logic [31:0] w;
        int          t;
        int          s;
    } exp_t;

    exp_t q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cur_test = 0;
    int   step_idx = 0;
    int   mw_cnt   = 0;
    int   hiin_cnt = 0;

    // Monitor: compare the presented control word against the oldest expectation
    always @(negedge clock) begin
        exp_t e;
        if (memwrite === 1'b1) mw_cnt++;
        if (HiIn === 1'b1) hiin_cnt++;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_tests++;
            if (dut_word !== e.w) begin
                n_fail++;
                $display("FAIL ctrl t%0d.s%0d: got %h expected %h", e.t, e.s, dut_word, e.w);
            end
        end
    end

    task automatic step(input logic [31:0] e);
        exp_t x;
        x.w = e;
        x.t = cur_test;
        x.s = step_idx;
        q.push_back(x);
        step_idx++;
        @(posedge clock);
        #1;
    endtask

    task automatic begin_instr(input logic [31:0] ir, input logic con);
        IR       = ir;
        ConOut   = con;
        cur_test++;
        step_idx = 0;
    endtask

    task automatic fetch();
        step(E_T0);
        step(E_T1);
        step(E_T2);
    endtask

    // Load-family T3/T4 are shared by ld, ldi and st
    localparam logic [31:0] E_LD3 = K_RUN | K_GRB | K_BAOUT | K_YIN;
    localparam logic [31:0] E_LD4 = K_RUN | K_COUT | K_ZIN | {1'b0, 5'b00011, 26'd0};

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        clear  = 1'b0;
        IR     = 32'd0;
        ConOut = 1'b0;
        @(posedge clock);
        #1;
        // Reset held two cycles, then released
        step(K_RUN);
        clear = 1'b1;
        step(K_RUN);

        // mflo R3
        begin_instr(32'hC180_0000, 1'b0);
        fetch();
        step(K_RUN | K_LOOUT | K_GRA | K_RIN);

        // ld R1,0x55(R2)
        begin_instr(32'h0090_0055, 1'b0);
        fetch();
        step(E_LD3);
        step(E_LD4);
        step(K_RUN | K_ZLOOUT | K_MARIN);
        step(K_RUN | K_MEMRD | K_MDRIN);
        step(K_RUN | K_MDROUT | K_GRA | K_RIN);

        // st R1,0x20(R0)
        begin_instr(32'h1080_0020, 1'b0);
        fetch();
        step(E_LD3);
        step(E_LD4);
        step(K_RUN | K_ZLOOUT | K_MARIN);
        step(K_RUN | K_GRA | K_ROUT | K_MDRIN);
        step(K_RUN | K_MEMWR);

        // ldi
        begin_instr(32'h0880_0007, 1'b0);
        fetch();
        step(E_LD3);
        step(E_LD4);
        step(K_RUN | K_ZLOOUT | K_GRA | K_RIN);

        // add (ALUCode follows the opcode)
        begin_instr(32'h1900_0000, 1'b0);
        fetch();
        step(K_RUN | K_GRB | K_ROUT | K_YIN);
        step(K_RUN | K_GRC | K_ROUT | K_ZIN | alu(5'b00011));
        step(K_RUN | K_ZLOOUT | K_GRA | K_RIN);

        // rol: top of the R-type range
        begin_instr(32'h5000_0000, 1'b0);
        fetch();
        step(K_RUN | K_GRB | K_ROUT | K_YIN);
        step(K_RUN | K_GRC | K_ROUT | K_ZIN | alu(5'b01010));
        step(K_RUN | K_ZLOOUT | K_GRA | K_RIN);

        // andi: immediate form uses COut
        begin_instr(32'h6000_0000, 1'b0);
        fetch();
        step(K_RUN | K_GRB | K_ROUT | K_YIN);
        step(K_RUN | K_COUT | K_ZIN | alu(5'b01100));
        step(K_RUN | K_ZLOOUT | K_GRA | K_RIN);

        // not
        begin_instr(32'h8800_0000, 1'b0);
        fetch();
        step(K_RUN | K_GRB | K_ROUT | K_ZIN | alu(5'b10001));
        step(K_RUN | K_ZLOOUT | K_GRA | K_RIN);

        // branch taken
        begin_instr(32'h9000_0000, 1'b1);
        fetch();
        step(K_RUN | K_GRA | K_ROUT | K_CONIN);
        step(K_RUN | K_PCOUT | K_YIN);
        step(K_RUN | K_COUT | K_ZIN | alu(5'b00011));
        step(K_RUN | K_ZLOOUT | K_PCIN);

        // branch not taken: PCIn stays low
        begin_instr(32'h9000_0000, 1'b0);
        fetch();
        step(K_RUN | K_GRA | K_ROUT | K_CONIN);
        step(K_RUN | K_PCOUT | K_YIN);
        step(K_RUN | K_COUT | K_ZIN | alu(5'b00011));
        step(K_RUN | K_ZLOOUT);

        // jr, jal
        begin_instr(32'h9800_0000, 1'b0);
        fetch();
        step(K_RUN | K_GRA | K_ROUT | K_PCIN);
        begin_instr(32'hA000_0000, 1'b0);
        fetch();
        step(K_RUN | K_PCOUT | K_GRB | K_RIN);
        step(K_RUN | K_GRA | K_ROUT | K_PCIN);

        // in, out, mfhi
        begin_instr(32'hA800_0000, 1'b0);
        fetch();
        step(K_RUN | K_IPOUT | K_GRA | K_RIN);
        begin_instr(32'hB000_0000, 1'b0);
        fetch();
        step(K_RUN | K_GRA | K_ROUT | K_OPIN);
        begin_instr(32'hB800_0000, 1'b0);
        fetch();
        step(K_RUN | K_HIOUT | K_GRA | K_RIN);

        // nop and an undefined opcode both return straight to T0
        begin_instr(32'hC800_0000, 1'b0);
        fetch();
        begin_instr(32'hD800_0000, 1'b0);
        fetch();

        // mul
        begin_instr(32'h7000_0000, 1'b0);
        fetch();
`ifdef CTRL_MULDIV_EN
        step(K_RUN | K_GRA | K_ROUT | K_YIN);
        step(K_RUN | K_GRB | K_ROUT | K_ZIN | alu(5'b01110));
        step(K_RUN | K_ZLOOUT | K_LOIN);
        step(K_RUN | K_ZHIOUT | K_HIIN);
`endif

        // ld interrupted by reset in T5
        begin_instr(32'h0090_0055, 1'b0);
        fetch();
        step(E_LD3);
        step(E_LD4);
        clear = 1'b0;
        step(K_RUN | K_ZLOOUT | K_MARIN);
        clear = 1'b1;
        step(K_RUN);

        // halt: frozen for 20 cycles, then reset recovers
        begin_instr(32'hD000_0000, 1'b0);
        fetch();
        for (int i = 0; i < 20; i++) step(32'd0);
        clear = 1'b0;
        step(32'd0);
        clear = 1'b1;
        step(K_RUN);
        step(E_T0);

        @(negedge clock);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending required 0", q.size());
        end
        n_tests++;
        if (mw_cnt != 1) begin
            n_fail++;
            $display("FAIL memwrite_pulses: got %0d required 1", mw_cnt);
        end
        n_tests++;
`ifdef CTRL_MULDIV_EN
        if (hiin_cnt != 1) begin
            n_fail++;
            $display("FAIL hiin_pulses: got %0d required 1", hiin_cnt);
        end
`else
        if (hiin_cnt != 0) begin
            n_fail++;
            $display("FAIL hiin_pulses: got %0d required 0", hiin_cnt);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
